// File: rtl/cam_pkg.sv
// Shared definitions for the camera byte-interface blocks (16b->8b transmitter
// and the matching 8b->16b receiver).
//   cam_state_t     : 2-bit transmitter state; the state names what is on the
//                     byte outputs during the current cycle.
//   HBLANK_MIN_DEF  : default minimum horizontal blanking gap, in cycles.
//   LINE_PIXELS_DEF : default expected pixels per line.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // nothing on the bus, waiting for a pixel
        ST_HI    = 2'd1,   // high byte on data_o
        ST_LO    = 2'd2,   // low byte on data_o
        ST_BLANK = 2'd3    // enforced horizontal blanking
    } cam_state_t;

    localparam int HBLANK_MIN_DEF  = 4;
    localparam int LINE_PIXELS_DEF = 640;

endpackage

// File: rtl/cam_hblank_timer.sv
// Loadable down-counter that times the horizontal blanking interval.
//   pixel_clk : clock, rising edge
//   rst       : asynchronous active-high reset (count -> 0)
//   load      : load load_val into the counter (has priority over tick)
//   tick      : decrement by one (holds at zero)
//   load_val  : value to load
//   done      : count is 1, i.e. this is the final blanking cycle
module cam_hblank_timer #(
    parameter int W = 8
) (
    input  logic         pixel_clk,
    input  logic         rst,
    input  logic         load,
    input  logic         tick,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/cam_16b8b.sv
// 16-bit pixel to 8-bit byte-stream serializer, high byte first, with a
// data-enable strobe, enforced horizontal blanking after every line and sticky
// underrun / line-length error flags.
//   pixel_clk      : clock, rising edge
//   rst            : asynchronous active-high reset
//   data_i         : pixel word, [15:8] sent first
//   data_valid_i   : data_i valid
//   data_last_i    : data_i is the last pixel of the line
//   data_ready_o   : block accepts data_i this cycle (transfer = valid & ready)
//   data_o         : output byte, 8'h00 whenever data_de_o is low
//   data_de_o      : data_o carries a byte
//   hblank_o       : enforced blanking interval in progress
//   err_underrun_o : sticky, source stalled mid-line
//   err_len_o      : sticky, a line ended with a pixel count != LINE_PIXELS
module cam_16b8b
    import cam_pkg::*;
#(
    parameter int HBLANK_MIN  = HBLANK_MIN_DEF,
    parameter int LINE_PIXELS = LINE_PIXELS_DEF,
    parameter int CNT_W       = 10
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        data_valid_i,
    input  logic        data_last_i,
    output logic        data_ready_o,
    output logic [7:0]  data_o,
    output logic        data_de_o,
    output logic        hblank_o,
    output logic        err_underrun_o,
    output logic        err_len_o
);

    cam_state_t       state, state_d;
    logic [7:0]       lo_q;
    logic             last_q;
    logic [CNT_W-1:0] pix_cnt;
    logic [7:0]       data_d;
    logic             transfer;
    logic             take;         // capture a new pixel this cycle
    logic             line_end;     // leaving the low byte of the last pixel
    logic             set_underrun;
    logic             blank_load;
    logic             blank_tick;
    logic             blank_done;

    // Ready only when the next cycle is free for a new high byte: from IDLE, or
    // back-to-back out of a low byte that does not close the line.
    assign data_ready_o = !rst && (state == ST_IDLE || (state == ST_LO && !last_q));
    assign transfer     = data_valid_i && data_ready_o;

    // Strobes decode straight from the state register, so reset clears them
    // asynchronously along with the state.
    assign data_de_o = (state == ST_HI) || (state == ST_LO);
    assign hblank_o  = (state == ST_BLANK);

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state;
        data_d       = 8'h00;
        take         = 1'b0;
        line_end     = 1'b0;
        set_underrun = 1'b0;
        blank_load   = 1'b0;
        blank_tick   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (transfer) begin
                    state_d = ST_HI;
                    data_d  = data_i[15:8];
                    take    = 1'b1;
                end
            end
            ST_HI: begin
                state_d = ST_LO;
                data_d  = lo_q;
            end
            ST_LO: begin
                if (last_q) begin
                    state_d    = ST_BLANK;
                    line_end   = 1'b1;
                    blank_load = 1'b1;
                end else if (transfer) begin
                    state_d = ST_HI;
                    data_d  = data_i[15:8];
                    take    = 1'b1;
                end else begin
                    // Source stalled mid-line; the line resumes from IDLE.
                    state_d      = ST_IDLE;
                    set_underrun = 1'b1;
                end
            end
            ST_BLANK: begin
                blank_tick = 1'b1;
                if (blank_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            data_o         <= 8'h00;
            lo_q           <= 8'h00;
            last_q         <= 1'b0;
            pix_cnt        <= '0;
            err_underrun_o <= 1'b0;
            err_len_o      <= 1'b0;
        end else begin
            state  <= state_d;
            data_o <= data_d;
            if (take) begin
                lo_q   <= data_i[7:0];
                last_q <= data_last_i;
                // Saturate rather than wrap so an overlong line is still flagged.
                if (pix_cnt != {CNT_W{1'b1}}) pix_cnt <= pix_cnt + 1'b1;
            end
            if (line_end) begin
                if (pix_cnt != CNT_W'(LINE_PIXELS)) err_len_o <= 1'b1;
                pix_cnt <= '0;
            end
            if (set_underrun) err_underrun_o <= 1'b1;
        end
    end

    cam_hblank_timer #(.W(8)) u_hblank_timer (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .load      (blank_load),
        .tick      (blank_tick),
        .load_val  (8'(HBLANK_MIN)),
        .done      (blank_done)
    );

endmodule
